apb2axi_txn_mgr: RTL and testbench

- Consumer stage directly downstream of the request directory.
- Pops ALLOCATED descriptors and issues them as single AXI4 bursts on AR or AW/W. Uses the directory tag as AXI ID.
- Tracks beats and worst response per tag, then returns one completion per tag to the directory on the dir_cpl_* handshake.
- Runs on the pclk domain.

---
 rtl/apb2axi_pkg.sv | 48 ++++
 rtl/apb2axi_txn_mgr_if.sv | 62 ++++++
 rtl/apb2axi_rsp_tracker.sv | 145 ++++++++++++++
 rtl/apb2axi_txn_mgr.sv | 193 +++++++++++++++++++
 tb/tb_apb2axi_txn_mgr.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb2axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb2axi_pkg                                            |
// | Description : Shared types, widths and AXI encodings for the APB to  |
// |               AXI bridge transaction manager.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package apb2axi_pkg;

  localparam int TAG_NUM    = 8;
  localparam int TAG_W      = 3;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Descriptor handed over by the request directory
  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic                  is_write;
  } directory_entry_t;

  // Issue FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_ADDR = 2'd1,
    ST_WR_ADDR = 2'd2,
    ST_WR_DATA = 2'd3
  } issue_state_t;

  // Worst-of two AXI responses (encodings are ordered by severity)
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Beat counter increment that sticks at 255
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb2axi_txn_mgr_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb2axi_txn_mgr_if                                     |
// | Description : AXI4 master bus (AW/W/B/AR/R) used by the transaction  |
// |               manager.                                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface apb2axi_txn_mgr_if;
  import apb2axi_pkg::*;

  logic [TAG_W-1:0]        awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [TAG_W-1:0]        bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [TAG_W-1:0]        arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [TAG_W-1:0]        rid;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface
`default_nettype wire

// File: rtl/apb2axi_rsp_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb2axi_rsp_tracker                                    |
// | Description : Per-tag busy/len/beat/resp tracking, B-vs-R            |
// |               arbitration and the single-entry completion register.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module apb2axi_rsp_tracker
  import apb2axi_pkg::*;
#(
  parameter int TAG_NUM_P    = TAG_NUM,
  parameter int TAG_W_P      = TAG_W,
  parameter int AXI_DATA_W_P = AXI_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pop_fire,
  input  logic [TAG_W_P-1:0]      pop_tag,
  input  logic [7:0]              pop_len,
  input  logic                    ar_fire,
  input  logic [TAG_W_P-1:0]      ar_tag,
  input  logic                    aw_fire,
  input  logic [TAG_W_P-1:0]      aw_tag,
  input  logic [TAG_W_P-1:0]      bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [TAG_W_P-1:0]      rid,
  input  logic [AXI_DATA_W_P-1:0] rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic                    rd_valid,
  output logic [AXI_DATA_W_P-1:0] rd_data,
  output logic [TAG_W_P-1:0]      rd_tag,
  output logic                    rd_last,
  output logic                    cpl_valid,
  output logic [TAG_W_P-1:0]      cpl_tag,
  output logic                    cpl_is_write,
  output logic                    cpl_error,
  output logic [1:0]              cpl_resp,
  output logic [7:0]              cpl_num_beats,
  input  logic                    cpl_ready,
  output logic                    cpl_fire,
  output logic                    protocol_err
);

  logic [TAG_NUM_P-1:0] rd_busy;
  logic [TAG_NUM_P-1:0] wr_busy;
  logic [7:0]           len_q   [TAG_NUM_P];
  logic [7:0]           beats_q [TAG_NUM_P];
  logic [1:0]           resp_q  [TAG_NUM_P];

  logic       b_fire, r_fire, b_hit, r_hit;
  logic [7:0] r_beats_nxt;
  logic [1:0] r_resp_nxt;
  logic [8:0] r_len_plus1;

  // A final R beat waits while the completion slot is taken or a B is
  // competing for it; B always wins the slot.
  assign bready   = !cpl_valid;
  assign rready   = !(rlast && (cpl_valid || bvalid));
  assign b_fire   = bvalid && bready;
  assign r_fire   = rvalid && rready;
  assign b_hit    = wr_busy[bid];
  assign r_hit    = rd_busy[rid];
  assign cpl_fire = cpl_valid && cpl_ready;

  // Accepted beats for known IDs go straight to the read-data sink
  assign rd_valid = r_fire && r_hit;
  assign rd_data  = rd_valid ? rdata : '0;
  assign rd_tag   = rd_valid ? rid : '0;
  assign rd_last  = rd_valid && rlast;

  assign r_beats_nxt = sat_inc(beats_q[rid]);
  assign r_resp_nxt  = resp_max(resp_q[rid], rresp);
  assign r_len_plus1 = {1'b0, len_q[rid]} + 9'd1;

  // Per-tag state, completion register and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_busy       <= '0;
      wr_busy       <= '0;
      for (int i = 0; i < TAG_NUM_P; i++) begin
        len_q[i]   <= '0;
        beats_q[i] <= '0;
        resp_q[i]  <= '0;
      end
      cpl_valid     <= 1'b0;
      cpl_tag       <= '0;
      cpl_is_write  <= 1'b0;
      cpl_error     <= 1'b0;
      cpl_resp      <= '0;
      cpl_num_beats <= '0;
      protocol_err  <= 1'b0;
    end else begin
      if (cpl_fire) cpl_valid <= 1'b0;

      if (b_fire) begin
        if (b_hit) begin
          cpl_valid     <= 1'b1;
          cpl_tag       <= bid;
          cpl_is_write  <= 1'b1;
          cpl_resp      <= bresp;
          cpl_error     <= (bresp >= AXI_RESP_SLVERR);
          cpl_num_beats <= len_q[bid] + 8'd1;
          wr_busy[bid]  <= 1'b0;
        end else begin
          protocol_err <= 1'b1;
        end
      end

      if (r_fire) begin
        if (r_hit) begin
          beats_q[rid] <= r_beats_nxt;
          resp_q[rid]  <= r_resp_nxt;
          if (rlast) begin
            cpl_valid     <= 1'b1;
            cpl_tag       <= rid;
            cpl_is_write  <= 1'b0;
            cpl_resp      <= r_resp_nxt;
            cpl_error     <= (r_resp_nxt >= AXI_RESP_SLVERR) ||
                             ({1'b0, r_beats_nxt} != r_len_plus1);
            cpl_num_beats <= r_beats_nxt;
            rd_busy[rid]  <= 1'b0;
          end
        end else begin
          protocol_err <= 1'b1;
        end
      end

      if (ar_fire) rd_busy[ar_tag] <= 1'b1;
      if (aw_fire) wr_busy[aw_tag] <= 1'b1;

      if (pop_fire) begin
        len_q[pop_tag]   <= pop_len;
        beats_q[pop_tag] <= '0;
        resp_q[pop_tag]  <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb2axi_txn_mgr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb2axi_txn_mgr                                        |
// | Description : Pops directory descriptors, issues them as single AXI4 |
// |               bursts and returns one completion per tag.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module apb2axi_txn_mgr
  import apb2axi_pkg::*;
#(
  parameter int TAG_NUM_P    = TAG_NUM,
  parameter int TAG_W_P      = TAG_W,
  parameter int MAX_OUTST_P  = 4,
  parameter int AXI_ADDR_W_P = AXI_ADDR_W,
  parameter int AXI_DATA_W_P = AXI_DATA_W
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      dir_pop_valid,
  input  directory_entry_t          dir_pop_entry,
  input  logic [TAG_W_P-1:0]        dir_pop_tag,
  output logic                      dir_pop_ready,
  output logic                      dir_cpl_valid,
  output logic [TAG_W_P-1:0]        dir_cpl_tag,
  output logic                      dir_cpl_is_write,
  output logic                      dir_cpl_error,
  output logic [1:0]                dir_cpl_resp,
  output logic [7:0]                dir_cpl_num_beats,
  input  logic                      dir_cpl_ready,
  input  logic                      wd_valid,
  input  logic [AXI_DATA_W_P-1:0]   wd_data,
  input  logic [AXI_DATA_W_P/8-1:0] wd_strb,
  output logic                      wd_ready,
  output logic                      rd_valid,
  output logic [AXI_DATA_W_P-1:0]   rd_data,
  output logic [TAG_W_P-1:0]        rd_tag,
  output logic                      rd_last,
  apb2axi_txn_mgr_if.master         axi,
  output logic                      protocol_err
);

  localparam int                OUT_W = $clog2(MAX_OUTST_P + 1);
  localparam logic [OUT_W-1:0]  MAX_C = OUT_W'(MAX_OUTST_P);

  issue_state_t              state;
  logic [OUT_W-1:0]          outst_cnt;
  logic [7:0]                wbeat;
  logic [TAG_W_P-1:0]        ar_id, aw_id;
  logic [AXI_ADDR_W_P-1:0]   ar_addr, aw_addr;
  logic [7:0]                ar_len, aw_len;
  logic [2:0]                ar_size, aw_size;
  logic                      ar_valid, aw_valid;
  logic                      pop_fire, issue_rd, issue_wr, in_wdata, w_fire, cpl_fire;

  assign dir_pop_ready = (state == ST_IDLE) && (outst_cnt < MAX_C);
  assign pop_fire      = dir_pop_valid && dir_pop_ready;
  assign issue_rd      = ar_valid && axi.arready;
  assign issue_wr      = aw_valid && axi.awready;

  // Write data is only exposed once the AW handshake has happened
  assign in_wdata   = (state == ST_WR_DATA);
  assign axi.wvalid = in_wdata && wd_valid;
  assign wd_ready   = in_wdata && axi.wready;
  assign axi.wdata  = in_wdata ? wd_data : '0;
  assign axi.wstrb  = in_wdata ? wd_strb : '0;
  assign axi.wlast  = in_wdata && (wbeat == 8'd0);
  assign w_fire     = axi.wvalid && axi.wready;

  assign axi.arid    = ar_id;
  assign axi.araddr  = ar_addr;
  assign axi.arlen   = ar_len;
  assign axi.arsize  = ar_size;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = ar_valid;
  assign axi.awid    = aw_id;
  assign axi.awaddr  = aw_addr;
  assign axi.awlen   = aw_len;
  assign axi.awsize  = aw_size;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awvalid = aw_valid;

  // Issue FSM: pop a descriptor, present its address, stream write beats
  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= ST_IDLE;
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_valid <= 1'b0;
      aw_id    <= '0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_valid <= 1'b0;
      wbeat    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop_fire) begin
            if (dir_pop_entry.is_write) begin
              aw_id    <= dir_pop_tag;
              aw_addr  <= dir_pop_entry.addr;
              aw_len   <= dir_pop_entry.len;
              aw_size  <= dir_pop_entry.size;
              aw_valid <= 1'b1;
              state    <= ST_WR_ADDR;
            end else begin
              ar_id    <= dir_pop_tag;
              ar_addr  <= dir_pop_entry.addr;
              ar_len   <= dir_pop_entry.len;
              ar_size  <= dir_pop_entry.size;
              ar_valid <= 1'b1;
              state    <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (issue_rd) begin
            ar_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_WR_ADDR: begin
          if (issue_wr) begin
            aw_valid <= 1'b0;
            wbeat    <= aw_len;
            state    <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (w_fire) begin
            if (wbeat == 8'd0) state <= ST_IDLE;
            else               wbeat <= wbeat - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bursts in flight: up on address handshake, down on completion handshake
  always_ff @(posedge pclk) begin
    if (preset) begin
      outst_cnt <= '0;
    end else if ((issue_rd || issue_wr) && !cpl_fire) begin
      outst_cnt <= outst_cnt + OUT_W'(1);
    end else if (!(issue_rd || issue_wr) && cpl_fire) begin
      outst_cnt <= outst_cnt - OUT_W'(1);
    end
  end

  apb2axi_rsp_tracker #(
    .TAG_NUM_P    (TAG_NUM_P),
    .TAG_W_P      (TAG_W_P),
    .AXI_DATA_W_P (AXI_DATA_W_P)
  ) u_rsp_tracker (
    .clk           (pclk),
    .rst           (preset),
    .pop_fire      (pop_fire),
    .pop_tag       (dir_pop_tag),
    .pop_len       (dir_pop_entry.len),
    .ar_fire       (issue_rd),
    .ar_tag        (ar_id),
    .aw_fire       (issue_wr),
    .aw_tag        (aw_id),
    .bid           (axi.bid),
    .bresp         (axi.bresp),
    .bvalid        (axi.bvalid),
    .bready        (axi.bready),
    .rid           (axi.rid),
    .rdata         (axi.rdata),
    .rresp         (axi.rresp),
    .rlast         (axi.rlast),
    .rvalid        (axi.rvalid),
    .rready        (axi.rready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_tag        (rd_tag),
    .rd_last       (rd_last),
    .cpl_valid     (dir_cpl_valid),
    .cpl_tag       (dir_cpl_tag),
    .cpl_is_write  (dir_cpl_is_write),
    .cpl_error     (dir_cpl_error),
    .cpl_resp      (dir_cpl_resp),
    .cpl_num_beats (dir_cpl_num_beats),
    .cpl_ready     (dir_cpl_ready),
    .cpl_fire      (cpl_fire),
    .protocol_err  (protocol_err)
  );

endmodule
`default_nettype wire

// File: tb/tb_apb2axi_txn_mgr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_apb2axi_txn_mgr                                     |
// | Description : Directed self-checking bench for apb2axi_txn_mgr.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_apb2axi_txn_mgr;
  import apb2axi_pkg::*;

  logic                    pclk = 1'b0;
  logic                    preset;
  logic                    dir_pop_valid;
  directory_entry_t        dir_pop_entry;
  logic [TAG_W-1:0]        dir_pop_tag;
  logic                    dir_pop_ready;
  logic                    dir_cpl_valid;
  logic [TAG_W-1:0]        dir_cpl_tag;
  logic                    dir_cpl_is_write;
  logic                    dir_cpl_error;
  logic [1:0]              dir_cpl_resp;
  logic [7:0]              dir_cpl_num_beats;
  logic                    dir_cpl_ready;
  logic                    wd_valid;
  logic [AXI_DATA_W-1:0]   wd_data;
  logic [AXI_DATA_W/8-1:0] wd_strb;
  logic                    wd_ready;
  logic                    rd_valid;
  logic [AXI_DATA_W-1:0]   rd_data;
  logic [TAG_W-1:0]        rd_tag;
  logic                    rd_last;
  logic                    protocol_err;

  int n_checks = 0;
  int n_errors = 0;

  apb2axi_txn_mgr_if axi ();

  always #5 pclk = ~pclk;

  apb2axi_txn_mgr #(.MAX_OUTST_P(4)) dut (
    .pclk              (pclk),
    .preset            (preset),
    .dir_pop_valid     (dir_pop_valid),
    .dir_pop_entry     (dir_pop_entry),
    .dir_pop_tag       (dir_pop_tag),
    .dir_pop_ready     (dir_pop_ready),
    .dir_cpl_valid     (dir_cpl_valid),
    .dir_cpl_tag       (dir_cpl_tag),
    .dir_cpl_is_write  (dir_cpl_is_write),
    .dir_cpl_error     (dir_cpl_error),
    .dir_cpl_resp      (dir_cpl_resp),
    .dir_cpl_num_beats (dir_cpl_num_beats),
    .dir_cpl_ready     (dir_cpl_ready),
    .wd_valid          (wd_valid),
    .wd_data           (wd_data),
    .wd_strb           (wd_strb),
    .wd_ready          (wd_ready),
    .rd_valid          (rd_valid),
    .rd_data           (rd_data),
    .rd_tag            (rd_tag),
    .rd_last           (rd_last),
    .axi               (axi.master),
    .protocol_err      (protocol_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_pop(input logic wr, input int tag, input logic [31:0] addr, input logic [7:0] len);
    dir_pop_valid          = 1'b1;
    dir_pop_tag            = TAG_W'(tag);
    dir_pop_entry.addr     = addr;
    dir_pop_entry.len      = len;
    dir_pop_entry.size     = 3'd2;
    dir_pop_entry.is_write = wr;
    tick();
    dir_pop_valid = 1'b0;
  endtask

  task automatic issue_rd(input int tag, input logic [31:0] addr, input logic [7:0] len);
    do_pop(1'b0, tag, addr, len);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
  endtask

  task automatic r_beat(input int tag, input logic [31:0] data, input logic [1:0] resp, input logic last);
    axi.rvalid = 1'b1;
    axi.rid    = TAG_W'(tag);
    axi.rdata  = data;
    axi.rresp  = resp;
    axi.rlast  = last;
    tick();
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
  endtask

  task automatic take_cpl(input int tag, input logic wr, input int beats, input logic [1:0] resp, input logic err);
    settle();
    check("cpl_valid", dir_cpl_valid, 1);
    check("cpl_tag", dir_cpl_tag, tag);
    check("cpl_is_write", dir_cpl_is_write, wr);
    check("cpl_num_beats", dir_cpl_num_beats, beats);
    check("cpl_resp", dir_cpl_resp, resp);
    check("cpl_error", dir_cpl_error, err);
    dir_cpl_ready = 1'b1;
    tick();
    dir_cpl_ready = 1'b0;
    settle();
    check("cpl_valid_clr", dir_cpl_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1;
    dir_pop_valid = 1'b0;
    dir_pop_entry = '0;
    dir_pop_tag   = '0;
    dir_cpl_ready = 1'b0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '1;
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bid = '0; axi.bresp = '0; axi.bvalid = 1'b0;
    axi.arready = 1'b0;
    axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    repeat (3) tick();
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid", axi.wvalid, 0);
    check("rst_cpl_valid", dir_cpl_valid, 0);
    check("rst_protocol_err", protocol_err, 0);
    check("rst_araddr", axi.araddr, 0);
    preset = 1'b0;
    tick();
    check("idle_pop_ready", dir_pop_ready, 1);

    // Read len=3 tag=2
    do_pop(1'b0, 2, 32'h1000, 8'd3);
    check("rd_arvalid", axi.arvalid, 1);
    check("rd_arid", axi.arid, 2);
    check("rd_arlen", axi.arlen, 3);
    check("rd_araddr", axi.araddr, 32'h1000);
    check("rd_arburst", axi.arburst, AXI_BURST_INCR);
    check("rd_busy_pop_ready", dir_pop_ready, 0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    check("rd_arvalid_drop", axi.arvalid, 0);
    for (int i = 0; i < 4; i++) begin
      axi.rvalid = 1'b1; axi.rid = 3'd2; axi.rdata = 32'hA0 + i;
      axi.rresp = AXI_RESP_OKAY; axi.rlast = (i == 3);
      settle();
      check("rd_valid", rd_valid, 1);
      check("rd_tag", rd_tag, 2);
      check("rd_data", rd_data, 32'hA0 + i);
      check("rd_last", rd_last, (i == 3));
      tick();
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    take_cpl(2, 1'b0, 4, AXI_RESP_OKAY, 1'b0);

    // Write len=1 tag=5, awready delayed 3 cycles
    do_pop(1'b1, 5, 32'h2000, 8'd1);
    check("wr_awvalid", axi.awvalid, 1);
    check("wr_awid", axi.awid, 5);
    check("wr_awlen", axi.awlen, 1);
    wd_valid = 1'b1; wd_data = 32'h11; axi.wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("wr_no_early_wvalid", axi.wvalid, 0);
      check("wr_no_early_wd_ready", wd_ready, 0);
      tick();
    end
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    settle();
    check("wr_wvalid_b0", axi.wvalid, 1);
    check("wr_wlast_b0", axi.wlast, 0);
    check("wr_wdata_b0", axi.wdata, 32'h11);
    tick();
    wd_data = 32'h22;
    settle();
    check("wr_wlast_b1", axi.wlast, 1);
    check("wr_wdata_b1", axi.wdata, 32'h22);
    tick();
    wd_valid = 1'b0; axi.wready = 1'b0;
    settle();
    check("wr_wvalid_done", axi.wvalid, 0);
    axi.bvalid = 1'b1; axi.bid = 3'd5; axi.bresp = AXI_RESP_OKAY;
    settle();
    check("wr_bready", axi.bready, 1);
    tick();
    axi.bvalid = 1'b0;
    take_cpl(5, 1'b1, 2, AXI_RESP_OKAY, 1'b0);

    // Worst response and short burst
    issue_rd(1, 32'h3000, 8'd2);
    r_beat(1, 32'h1, AXI_RESP_OKAY, 1'b0);
    r_beat(1, 32'h2, AXI_RESP_SLVERR, 1'b0);
    r_beat(1, 32'h3, AXI_RESP_OKAY, 1'b1);
    take_cpl(1, 1'b0, 3, AXI_RESP_SLVERR, 1'b1);
    issue_rd(3, 32'h3100, 8'd3);
    r_beat(3, 32'h4, AXI_RESP_OKAY, 1'b0);
    r_beat(3, 32'h5, AXI_RESP_OKAY, 1'b1);
    take_cpl(3, 1'b0, 2, AXI_RESP_OKAY, 1'b1);

    // Outstanding limit: tags 0,1,2 reads and tag 3 write, all len=0
    issue_rd(0, 32'h4000, 8'd0);
    issue_rd(1, 32'h4100, 8'd0);
    issue_rd(2, 32'h4200, 8'd0);
    do_pop(1'b1, 3, 32'h4300, 8'd0);
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    wd_valid = 1'b1; wd_data = 32'h33; axi.wready = 1'b1;
    tick();
    wd_valid = 1'b0; axi.wready = 1'b0;
    settle();
    check("lim_pop_ready_full", dir_pop_ready, 0);
    dir_pop_valid = 1'b1; dir_pop_tag = 3'd4;
    dir_pop_entry.addr = 32'h4400; dir_pop_entry.len = 8'd0; dir_pop_entry.is_write = 1'b0;
    tick();
    check("lim_no_issue", axi.arvalid, 0);
    axi.rvalid = 1'b1; axi.rid = 3'd0; axi.rdata = 32'h40; axi.rresp = AXI_RESP_OKAY; axi.rlast = 1'b1;
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    settle();
    check("lim_cpl_tag0", dir_cpl_tag, 0);
    check("lim_pop_ready_cpl_pend", dir_pop_ready, 0);
    dir_cpl_ready = 1'b1;
    tick();
    dir_cpl_ready = 1'b0;
    check("lim_pop_ready_back", dir_pop_ready, 1);
    tick();
    dir_pop_valid = 1'b0;
    check("lim_5th_arvalid", axi.arvalid, 1);
    check("lim_5th_arid", axi.arid, 4);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;

    // Final R beat tag 1 and B tag 3 in the same cycle
    axi.rvalid = 1'b1; axi.rid = 3'd1; axi.rdata = 32'h51; axi.rresp = AXI_RESP_OKAY; axi.rlast = 1'b1;
    axi.bvalid = 1'b1; axi.bid = 3'd3; axi.bresp = AXI_RESP_OKAY;
    settle();
    check("arb_rready_low", axi.rready, 0);
    check("arb_bready_high", axi.bready, 1);
    tick();
    axi.bvalid = 1'b0;
    settle();
    check("arb_cpl_tag3", dir_cpl_tag, 3);
    check("arb_cpl_wr", dir_cpl_is_write, 1);
    check("arb_rready_hold1", axi.rready, 0);
    tick();
    check("arb_cpl_tag3_hold", dir_cpl_tag, 3);
    check("arb_cpl_beats", dir_cpl_num_beats, 1);
    check("arb_rready_hold2", axi.rready, 0);
    dir_cpl_ready = 1'b1;
    tick();
    dir_cpl_ready = 1'b0;
    settle();
    check("arb_rready_free", axi.rready, 1);
    check("arb_rd_valid", rd_valid, 1);
    check("arb_rd_data", rd_data, 32'h51);
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    take_cpl(1, 1'b0, 1, AXI_RESP_OKAY, 1'b0);
    r_beat(2, 32'h60, AXI_RESP_OKAY, 1'b1);
    take_cpl(2, 1'b0, 1, AXI_RESP_OKAY, 1'b0);
    r_beat(4, 32'h61, AXI_RESP_DECERR, 1'b1);
    take_cpl(4, 1'b0, 1, AXI_RESP_DECERR, 1'b1);

    // Response for an ID that is not outstanding
    axi.rvalid = 1'b1; axi.rid = 3'd6; axi.rdata = 32'h66; axi.rlast = 1'b1;
    settle();
    check("perr_rd_dropped", rd_valid, 0);
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    settle();
    check("perr_set", protocol_err, 1);
    check("perr_no_cpl", dir_cpl_valid, 0);
    tick();
    tick();
    check("perr_sticky", protocol_err, 1);

    // Reset in WR_DATA, then a B for the abandoned tag
    do_pop(1'b1, 7, 32'h5000, 8'd3);
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    wd_valid = 1'b1; wd_data = 32'h77; axi.wready = 1'b1;
    settle();
    check("wrst_wvalid_before", axi.wvalid, 1);
    preset = 1'b1;
    tick();
    check("wrst_wvalid", axi.wvalid, 0);
    check("wrst_wd_ready", wd_ready, 0);
    check("wrst_wdata", axi.wdata, 0);
    check("wrst_awvalid", axi.awvalid, 0);
    check("wrst_awaddr", axi.awaddr, 0);
    check("wrst_protocol_err", protocol_err, 0);
    check("wrst_cpl_valid", dir_cpl_valid, 0);
    preset = 1'b0; wd_valid = 1'b0; axi.wready = 1'b0;
    tick();
    axi.bvalid = 1'b1; axi.bid = 3'd7; axi.bresp = AXI_RESP_OKAY;
    tick();
    axi.bvalid = 1'b0;
    settle();
    check("wrst_abandoned_b_perr", protocol_err, 1);
    check("wrst_abandoned_no_cpl", dir_cpl_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
